// File: rtl/regfile_pkg.sv
// regfile_pkg: shared sizing constants and types for the writeback register file.
package regfile_pkg;
    localparam int XLEN       = 32;
    localparam int NREGS      = 32;
    localparam int REG_ADDR_W = 5;
    localparam int CNT_W      = 2;
    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]       xlen_t;
    typedef logic [CNT_W-1:0]      sb_cnt_t;
endpackage

// File: rtl/wb_regfile_scoreboard.sv
// wb_regfile_scoreboard: per-register in-flight write counters with issue stall and sticky underflow error.
//   clk, reset         clock, synchronous active-high reset
//   issue_valid_i/rd_i  issued instruction that will write rd
//   wb_we_i/wb_addr_i   retiring write from the WB delay stage
//   issue_stall_o       counter for issue_rd_i is saturated
//   sb_err_o            sticky: a write retired against a zero count
//   pending_o           bit r set while register r has outstanding writes
//   last_o              bit r set when exactly one write is outstanding
module wb_regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS = regfile_pkg::NREGS,
    parameter int CNT_W = regfile_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             issue_valid_i,
    input  reg_addr_t        issue_rd_i,
    input  logic             wb_we_i,
    input  reg_addr_t        wb_addr_i,
    output logic             issue_stall_o,
    output logic             sb_err_o,
    output logic [NREGS-1:0] pending_o,
    output logic [NREGS-1:0] last_o
);
    localparam logic [CNT_W-1:0] MAX = '1;
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q [NREGS];
    logic [CNT_W-1:0] cnt_d [NREGS];
    logic             err_q, err_d;
    logic             inc, dec, inc_r, dec_r;

    always_comb begin
        issue_stall_o = issue_valid_i && issue_rd_i != '0 && cnt_q[issue_rd_i] == MAX;
        inc           = issue_valid_i && issue_rd_i != '0 && !issue_stall_o;
        dec           = wb_we_i && wb_addr_i != '0 && cnt_q[wb_addr_i] != '0;
        // a retiring write with nothing outstanding is a bookkeeping error, latched until reset
        err_d         = err_q || (wb_we_i && wb_addr_i != '0 && cnt_q[wb_addr_i] == '0);
        cnt_d         = cnt_q;
        inc_r         = 1'b0;
        dec_r         = 1'b0;
        for (int r = 1; r < NREGS; r++) begin
            inc_r    = inc && issue_rd_i == reg_addr_t'(r);
            dec_r    = dec && wb_addr_i == reg_addr_t'(r);
            cnt_d[r] = (inc_r && !dec_r) ? cnt_q[r] + ONE :
                       (dec_r && !inc_r) ? cnt_q[r] - ONE : cnt_q[r];
        end
        pending_o = '0;
        last_o    = '0;
        for (int r = 0; r < NREGS; r++) begin
            pending_o[r] = cnt_q[r] != '0;
            last_o[r]    = cnt_q[r] == ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NREGS; r++) cnt_q[r] <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign sb_err_o = err_q;
endmodule

// File: rtl/wb_regfile.sv
// wb_regfile: integer register file fed by the delayed writeback port, with RAW hazard scoreboard.
//   clk, reset             clock, synchronous active-high reset (masks read data and hazards while high)
//   wb_we/wb_addr/wb_data  write port from the WB delay stage
//   rs1_*/rs2_*            combinational read ports for decode
//   issue_valid/issue_rd   decode issues an instruction writing issue_rd
//   hazard_rs1/2           source register has an outstanding write
//   issue_stall            issue_rd counter saturated; issuer must hold
//   sb_err                 sticky underflow error from the scoreboard
// Optional feature: define REGFILE_WB_BYPASS_EN to forward the retiring write to the read ports.
module wb_regfile
    import regfile_pkg::*;
#(
    parameter int XLEN  = regfile_pkg::XLEN,
    parameter int NREGS = regfile_pkg::NREGS,
    parameter int CNT_W = regfile_pkg::CNT_W
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            wb_we,
    input  reg_addr_t       wb_addr,
    input  logic [XLEN-1:0] wb_data,
    input  reg_addr_t       rs1_addr,
    input  reg_addr_t       rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    input  logic            issue_valid,
    input  reg_addr_t       issue_rd,
    output logic            hazard_rs1,
    output logic            hazard_rs2,
    output logic            issue_stall,
    output logic            sb_err
);
    logic [XLEN-1:0]  regs_q [NREGS];
    logic [NREGS-1:0] pending, last;
    logic             byp1, byp2;

    wb_regfile_scoreboard #(.NREGS(NREGS), .CNT_W(CNT_W)) u_sb (
        .clk           (clk),
        .reset         (reset),
        .issue_valid_i (issue_valid),
        .issue_rd_i    (issue_rd),
        .wb_we_i       (wb_we),
        .wb_addr_i     (wb_addr),
        .issue_stall_o (issue_stall),
        .sb_err_o      (sb_err),
        .pending_o     (pending),
        .last_o        (last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NREGS; r++) regs_q[r] <= '0;
        end else if (wb_we && wb_addr != '0) begin
            regs_q[wb_addr] <= wb_data;
        end
    end

    always_comb begin
`ifdef REGFILE_WB_BYPASS_EN
        byp1 = wb_we && wb_addr == rs1_addr && rs1_addr != '0;
        byp2 = wb_we && wb_addr == rs2_addr && rs2_addr != '0;
`else
        byp1 = 1'b0;
        byp2 = 1'b0;
`endif
        rs1_data   = (reset || rs1_addr == '0) ? '0 : byp1 ? wb_data : regs_q[rs1_addr];
        rs2_data   = (reset || rs2_addr == '0) ? '0 : byp2 ? wb_data : regs_q[rs2_addr];
        // the hazard drops early only when the bypassed write is the last one outstanding
        hazard_rs1 = !reset && rs1_addr != '0 && pending[rs1_addr] && !(byp1 && last[rs1_addr]);
        hazard_rs2 = !reset && rs2_addr != '0 && pending[rs2_addr] && !(byp2 && last[rs2_addr]);
    end
endmodule
